// File: rtl/regfile_sb.sv
// Scoreboarded register file: two bypassed read ports and one muxed write port.
// An in-order pending-load queue tracks outstanding loads, with a busy flag per register.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NREG     = 8,
    parameter int AW       = $clog2(NREG),
    parameter int IMM_W    = 8,
    parameter int LQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [1:0]        wr_src,
    input  logic [DATA_W-1:0] alu_wd,
    input  logic [IMM_W-1:0]  imm,
    input  logic [IMM_W-1:0]  im_rd,
    input  logic              ld_issue,
    input  logic [AW-1:0]     ld_addr,
    input  logic              ld_resp_valid,
    input  logic [DATA_W-1:0] ld_resp_data,
    output logic              ld_full,
    output logic              err
);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = $clog2(LQ_DEPTH + 1);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pending, pending_nxt;
    logic [AW-1:0]     lq [LQ_DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic              err_q;

    logic              q_empty, q_full, resp_pop, resp_err;
    logic [AW-1:0]     head;
    logic [DATA_W-1:0] wr_data;
    logic              wr_commit, wr_err;
    logic              iss_pend, iss_ok, iss_err;

    assign q_empty  = (count == '0);
    assign q_full   = (count == CW'(LQ_DEPTH));
    assign head     = lq[rd_ptr];
    assign resp_pop = ld_resp_valid & ~q_empty;
    assign resp_err = ld_resp_valid & q_empty;

    always_comb begin
        wr_data = alu_wd;
        case (wr_src)
            2'b01:   wr_data = {{(DATA_W-IMM_W){1'b0}}, imm};
            2'b10:   wr_data = {{(DATA_W-IMM_W){1'b0}}, im_rd};
            default: wr_data = alu_wd;
        endcase
    end

    // pending[0] is never set, so a write to r0 is silently dropped without err.
    assign wr_commit = wr_en & (wr_src != 2'b11) & (wr_addr != '0) & ~pending[wr_addr];
    assign wr_err    = wr_en & ((wr_src == 2'b11) | pending[wr_addr]);

    // A same-cycle response to the same register frees it for re-issue.
    assign iss_pend = pending[ld_addr] & ~(resp_pop & (head == ld_addr));
    assign iss_ok   = ld_issue & (~q_full | ld_resp_valid) & ~iss_pend;
    assign iss_err  = ld_issue & ~iss_ok;

    assign rd1 = (ra1 == '0) ? '0 :
                 (resp_pop && head == ra1) ? ld_resp_data :
                 (wr_commit && wr_addr == ra1) ? wr_data : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 :
                 (resp_pop && head == ra2) ? ld_resp_data :
                 (wr_commit && wr_addr == ra2) ? wr_data : regs[ra2];

    assign busy1   = pending[ra1] & ~(resp_pop & (head == ra1));
    assign busy2   = pending[ra2] & ~(resp_pop & (head == ra2));
    assign ld_full = q_full;
    assign err     = err_q;

    always_comb begin
        pending_nxt = pending;
        if (resp_pop) pending_nxt[head] = 1'b0;
        if (iss_ok && ld_addr != '0) pending_nxt[ld_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            pending <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            err_q   <= 1'b0;
        end else begin
            // A load response outranks the arch write; they never collide since
            // a write to a pending register is dropped.
            if (wr_commit) regs[wr_addr] <= wr_data;
            if (resp_pop) begin
                if (head != '0) regs[head] <= ld_resp_data;
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (iss_ok) wr_ptr <= wr_ptr + PW'(1);
            pending <= pending_nxt;
            count   <= count + CW'(iss_ok) - CW'(resp_pop);
            if (wr_err || iss_err || resp_err) err_q <= 1'b1;
        end
    end

    // Queue storage needs no reset; entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (!rst && iss_ok) lq[wr_ptr] <= ld_addr;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, corner-case sequences and a
// randomized run against a queue/array reference model.
module tb_regfile_sb;
    logic        clk, rst;
    logic [2:0]  ra1, ra2, wr_addr, ld_addr;
    logic [31:0] rd1, rd2, alu_wd, ld_resp_data;
    logic        busy1, busy2, wr_en, ld_issue, ld_resp_valid, ld_full, err;
    logic [1:0]  wr_src;
    logic [7:0]  imm, im_rd;

    int checks = 0;
    int failures = 0;

    regfile_sb dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_src(wr_src), .alu_wd(alu_wd), .imm(imm), .im_rd(im_rd),
        .ld_issue(ld_issue), .ld_addr(ld_addr), .ld_resp_valid(ld_resp_valid),
        .ld_resp_data(ld_resp_data), .ld_full(ld_full), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; wr_en = 0; wr_addr = 0; wr_src = 0; alu_wd = 0; imm = 0; im_rd = 0;
        ld_issue = 0; ld_addr = 0; ld_resp_valid = 0; ld_resp_data = 0; ra1 = 0; ra2 = 0;
    endtask

    typedef struct {
        int we, wa, src, alu, imm, imr, iss, la, rv, rdata, ra1, ra2;
        int e1, e2, b1, b2, full, err;
    } vec_t;
    vec_t tv [34];

    // ---------------- reference model ----------------
    logic [31:0] m_regs [8];
    bit          m_pend [8];
    int          m_q [$];
    bit          m_err;

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
        m_q.delete();
        m_err = 0;
    endtask

    function automatic logic [31:0] m_wdata();
        case (wr_src)
            2'd1:    return {24'd0, imm};
            2'd2:    return {24'd0, im_rd};
            default: return alu_wd;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 0;
        if (ld_resp_valid && m_q.size() > 0 && m_q[0] == a) return ld_resp_data;
        if (wr_en && wr_src != 2'd3 && int'(wr_addr) == a && !m_pend[a]) return m_wdata();
        return m_regs[a];
    endfunction

    function automatic bit m_busy(input int a);
        return m_pend[a] && !(ld_resp_valid && m_q.size() > 0 && m_q[0] == a);
    endfunction

    task automatic m_check();
        chk("rnd_rd1", rd1, m_read(int'(ra1)));
        chk("rnd_rd2", rd2, m_read(int'(ra2)));
        chk("rnd_busy1", 32'(busy1), 32'(m_busy(int'(ra1))));
        chk("rnd_busy2", 32'(busy2), 32'(m_busy(int'(ra2))));
        chk("rnd_full", 32'(ld_full), 32'(m_q.size() == 2));
        chk("rnd_err", 32'(err), 32'(m_err));
    endtask

    task automatic m_update();
        bit ne, acc, still_pend;
        int head, la, wa;
        if (rst) begin m_reset(); return; end
        ne = m_q.size() > 0;
        head = ne ? m_q[0] : -1;
        la = int'(ld_addr);
        wa = int'(wr_addr);
        still_pend = m_pend[la] && !(ld_resp_valid && ne && head == la);
        acc = ld_issue && (m_q.size() < 2 || ld_resp_valid) && !still_pend;
        if (ld_issue && !acc) m_err = 1;
        if (wr_en) begin
            if (wr_src == 2'd3 || m_pend[wa]) m_err = 1;
            else if (wa != 0) m_regs[wa] = m_wdata();
        end
        if (ld_resp_valid) begin
            if (ne) begin
                void'(m_q.pop_front());
                if (head != 0) m_regs[head] = ld_resp_data;
                m_pend[head] = 0;
            end else m_err = 1;
        end
        if (acc) begin
            m_q.push_back(la);
            if (la != 0) m_pend[la] = 1;
        end
    endtask

    initial begin
        //          we wa src alu          imm   imr  iss la rv rdata        ra1 ra2 e1           e2           b1 b2 full err
        tv[0]  = '{1, 0, 0, 'hDEADBEEF, 0,    0,    0, 0, 0, 0,          0, 0, 0,           0,           0, 0, 0, 0};
        tv[1]  = '{1, 3, 1, 'h777,      'hA5, 0,    0, 0, 0, 0,          0, 3, 0,           'hA5,        0, 0, 0, 0};
        tv[2]  = '{0, 0, 0, 0,          0,    0,    0, 0, 0, 0,          3, 0, 'hA5,        0,           0, 0, 0, 0};
        tv[3]  = '{1, 5, 0, 'h12345678, 'h11, 0,    0, 0, 0, 0,          3, 5, 'hA5,        'h12345678,  0, 0, 0, 0};
        tv[4]  = '{0, 0, 0, 0,          0,    0,    0, 0, 0, 0,          5, 5, 'h12345678,  'h12345678,  0, 0, 0, 0};
        tv[5]  = '{1, 4, 2, 'h999,      'hFF, 'h3C, 0, 0, 0, 0,          4, 4, 'h3C,        'h3C,        0, 0, 0, 0};
        tv[6]  = '{0, 0, 0, 0,          0,    0,    1, 2, 0, 0,          2, 0, 0,           0,           0, 0, 0, 0};
        tv[7]  = '{0, 0, 0, 0,          0,    0,    0, 0, 0, 0,          2, 0, 0,           0,           1, 0, 0, 0};
        tv[8]  = '{0, 0, 0, 0,          0,    0,    0, 0, 0, 0,          2, 0, 0,           0,           1, 0, 0, 0};
        tv[9]  = '{0, 0, 0, 0,          0,    0,    0, 0, 1, 'hCAFEF00D, 2, 0, 'hCAFEF00D,  0,           0, 0, 0, 0};
        tv[10] = '{0, 0, 0, 0,          0,    0,    0, 0, 0, 0,          2, 0, 'hCAFEF00D,  0,           0, 0, 0, 0};
        tv[11] = '{0, 0, 0, 0,          0,    0,    1, 1, 0, 0,          1, 4, 0,           'h3C,        0, 0, 0, 0};
        tv[12] = '{0, 0, 0, 0,          0,    0,    1, 4, 0, 0,          1, 4, 0,           'h3C,        1, 0, 0, 0};
        tv[13] = '{0, 0, 0, 0,          0,    0,    0, 0, 0, 0,          1, 4, 0,           'h3C,        1, 1, 1, 0};
        tv[14] = '{0, 0, 0, 0,          0,    0,    1, 6, 0, 0,          6, 4, 0,           'h3C,        0, 1, 1, 0};
        tv[15] = '{0, 0, 0, 0,          0,    0,    0, 0, 1, 'h11,       1, 6, 'h11,        0,           0, 0, 1, 1};
        tv[16] = '{0, 0, 0, 0,          0,    0,    0, 0, 1, 'h44,       1, 4, 'h11,        'h44,        0, 0, 0, 1};
        tv[17] = '{0, 0, 0, 0,          0,    0,    0, 0, 0, 0,          1, 4, 'h11,        'h44,        0, 0, 0, 1};
        tv[18] = '{0, 0, 0, 0,          0,    0,    1, 3, 0, 0,          3, 5, 'hA5,        'h12345678,  0, 0, 0, 1};
        tv[19] = '{0, 0, 0, 0,          0,    0,    1, 5, 0, 0,          3, 5, 'hA5,        'h12345678,  1, 0, 0, 1};
        tv[20] = '{0, 0, 0, 0,          0,    0,    1, 6, 1, 'h33,       3, 6, 'h33,        0,           0, 0, 1, 1};
        tv[21] = '{0, 0, 0, 0,          0,    0,    0, 0, 0, 0,          6, 5, 0,           'h12345678,  1, 1, 1, 1};
        tv[22] = '{0, 0, 0, 0,          0,    0,    0, 0, 1, 'h55,       5, 3, 'h55,        'h33,        0, 0, 1, 1};
        tv[23] = '{0, 0, 0, 0,          0,    0,    0, 0, 1, 'h66,       6, 5, 'h66,        'h55,        0, 0, 0, 1};
        tv[24] = '{0, 0, 0, 0,          0,    0,    0, 0, 0, 0,          6, 5, 'h66,        'h55,        0, 0, 0, 1};
        tv[25] = '{1, 7, 0, 'h777,      0,    0,    1, 7, 0, 0,          7, 0, 'h777,       0,           0, 0, 0, 1};
        tv[26] = '{0, 0, 0, 0,          0,    0,    0, 0, 0, 0,          7, 0, 'h777,       0,           1, 0, 0, 1};
        tv[27] = '{1, 2, 0, 'h222,      0,    0,    0, 0, 1, 'h7070,     7, 2, 'h7070,      'h222,       0, 0, 0, 1};
        tv[28] = '{0, 0, 0, 0,          0,    0,    0, 0, 0, 0,          7, 2, 'h7070,      'h222,       0, 0, 0, 1};
        tv[29] = '{0, 0, 0, 0,          0,    0,    1, 1, 0, 0,          1, 0, 'h11,        0,           0, 0, 0, 1};
        tv[30] = '{0, 0, 0, 0,          0,    0,    1, 1, 1, 'h101,      1, 0, 'h101,       0,           0, 0, 0, 1};
        tv[31] = '{0, 0, 0, 0,          0,    0,    0, 0, 0, 0,          1, 0, 'h101,       0,           1, 0, 0, 1};
        tv[32] = '{0, 0, 0, 0,          0,    0,    0, 0, 1, 'h202,      1, 0, 'h202,       0,           0, 0, 0, 1};
        tv[33] = '{0, 0, 0, 0,          0,    0,    0, 0, 0, 0,          1, 0, 'h202,       0,           0, 0, 0, 1};

        // reset and r0..r7 readback
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            ra1 = 3'(i); ra2 = 3'(7 - i);
            #1;
            chk($sformatf("rst_rd1_r%0d", i), rd1, 0);
            chk($sformatf("rst_rd2_r%0d", 7 - i), rd2, 0);
        end
        chk("rst_busy1", 32'(busy1), 0);
        chk("rst_busy2", 32'(busy2), 0);
        chk("rst_full", 32'(ld_full), 0);
        chk("rst_err", 32'(err), 0);
        tick();

        // directed vector table, one row per cycle, outputs sampled before the edge
        for (int i = 0; i < 34; i++) begin
            idle();
            wr_en = tv[i].we[0]; wr_addr = tv[i].wa[2:0]; wr_src = tv[i].src[1:0];
            alu_wd = tv[i].alu; imm = tv[i].imm[7:0]; im_rd = tv[i].imr[7:0];
            ld_issue = tv[i].iss[0]; ld_addr = tv[i].la[2:0];
            ld_resp_valid = tv[i].rv[0]; ld_resp_data = tv[i].rdata;
            ra1 = tv[i].ra1[2:0]; ra2 = tv[i].ra2[2:0];
            #1;
            chk($sformatf("vec%0d_rd1", i), rd1, tv[i].e1);
            chk($sformatf("vec%0d_rd2", i), rd2, tv[i].e2);
            chk($sformatf("vec%0d_busy1", i), 32'(busy1), tv[i].b1);
            chk($sformatf("vec%0d_busy2", i), 32'(busy2), tv[i].b2);
            chk($sformatf("vec%0d_full", i), 32'(ld_full), tv[i].full);
            chk($sformatf("vec%0d_err", i), 32'(err), tv[i].err);
            tick();
        end

        // WAW on an in-flight load
        idle(); rst = 1; tick(); idle();
        ld_issue = 1; ld_addr = 6; tick(); idle();
        wr_en = 1; wr_addr = 6; alu_wd = 'h99; ra1 = 6;
        #1;
        chk("waw_no_bypass", rd1, 0);
        chk("waw_busy", 32'(busy1), 1);
        tick(); idle(); ra1 = 6;
        #1;
        chk("waw_r6", rd1, 0);
        chk("waw_err", 32'(err), 1);
        ld_resp_valid = 1; ld_resp_data = 'h66;
        #1;
        chk("waw_resp_bypass", rd1, 'h66);
        tick(); idle(); ra1 = 6;
        #1;
        chk("waw_resp_r6", rd1, 'h66);

        // response with empty queue
        idle(); rst = 1; tick(); idle();
        #1;
        chk("empty_pre_err", 32'(err), 0);
        ld_resp_valid = 1; ld_resp_data = 'hBAD; ra1 = 1;
        #1;
        chk("empty_no_bypass", rd1, 0);
        tick(); idle();
        #1;
        chk("empty_err", 32'(err), 1);
        for (int i = 1; i < 8; i++) begin
            ra1 = 3'(i);
            #1;
            chk($sformatf("empty_r%0d", i), rd1, 0);
        end

        // reset with a load in flight
        idle(); rst = 1; tick(); idle();
        ld_issue = 1; ld_addr = 7; tick(); idle(); ra1 = 7;
        #1;
        chk("midrst_busy_pre", 32'(busy1), 1);
        rst = 1; tick(); idle(); ra1 = 7;
        #1;
        chk("midrst_busy", 32'(busy1), 0);
        chk("midrst_full", 32'(ld_full), 0);
        chk("midrst_err_pre", 32'(err), 0);
        ld_resp_valid = 1; ld_resp_data = 'h1234;
        #1;
        chk("midrst_no_bypass", rd1, 0);
        tick(); idle(); ra1 = 7;
        #1;
        chk("midrst_r7", rd1, 0);
        chk("midrst_err", 32'(err), 1);

        // randomized run against the reference model
        idle(); rst = 1; tick();
        m_reset();
        for (int c = 0; c < 600; c++) begin
            idle();
            rst = ($urandom_range(0, 39) == 0);
            wr_en = ($urandom_range(0, 1) == 1);
            wr_addr = 3'($urandom_range(0, 7));
            wr_src = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            alu_wd = $urandom;
            imm = 8'($urandom);
            im_rd = 8'($urandom);
            ld_issue = ($urandom_range(0, 2) == 0);
            ld_addr = 3'($urandom_range(0, 7));
            ld_resp_valid = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                             : ($urandom_range(0, 24) == 0);
            ld_resp_data = $urandom;
            ra1 = 3'($urandom_range(0, 7));
            ra2 = 3'($urandom_range(0, 7));
            #1;
            m_check();
            @(posedge clk);
            m_update();
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, scoreboarded register file for the processor datapath: the next generation of the 8×32 register file. It provides two combinational read ports with write-through bypass and a single architectural write port with a selectable source (ALU, immediate, instruction-memory byte). It also adds an in-order pending-load queue, so data-memory loads retire asynchronously. Per-register busy flags let the decode stage stall on load-use hazards.

## Interface
- DATA_W, 32, register width
- NREG, 8, number of registers; r0 hardwired to zero
- AW, $clog2(NREG), register address width
- IMM_W, 8, immediate / instruction-memory byte width, zero-extended to DATA_W
- LQ_DEPTH, 2, pending-load queue depth (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  DATA_W  read data (combinational)
- busy1, busy2  out  1  register at ra1/ra2 awaits a load
- wr_en  in  1  architectural write request
- wr_addr  in  AW  write destination
- wr_src  in  2  00 alu_wd, 01 imm, 10 im_rd, 11 reserved (write dropped, err set)
- alu_wd  in  DATA_W  ALU result
- imm  in  IMM_W  immediate
- im_rd  in  IMM_W  instruction-memory read byte
- ld_issue  in  1  load issued; destination ld_addr becomes pending
- ld_addr  in  AW  load destination
- ld_resp_valid  in  1  data-memory response for oldest pending load
- ld_resp_data  in  DATA_W  load data
- ld_full  out  1  queue holds LQ_DEPTH entries
- err  out  1  sticky protocol-error flag

## Operation
- **State:** the state is:
  - regs[1..NREG-1];
  - a pending bit per register;
  - a FIFO of load destinations (LQ_DEPTH entries, with read/write pointers and a count);
  - the err bit.
- **Reset:** regs, pending, count, pointers and err are cleared. After reset: rd1 = rd2 = 0, busy1 = busy2 = 0, ld_full = 0, err = 0.
- **Architectural write:** wr_en commits the selected source to regs[wr_addr]. IMM_W sources are zero-extended.
  - The write is dropped if wr_addr == 0.
  - If pending[wr_addr] = 1, the write is dropped and err is set (WAW on an in-flight load).
- **Load issue:** accepted when count < LQ_DEPTH, or when count == LQ_DEPTH and ld_resp_valid is high in the same cycle.
  - Accept pushes ld_addr and sets pending[ld_addr]. For ld_addr == 0 the entry is pushed but no pending bit is set.
  - Issue when full without a response: dropped, err set.
  - Issue to an already-pending register: dropped, err set.
- **Load response:** pops the head entry and writes ld_resp_data to regs[head] (discarded if head == 0). It then clears pending[head].
  - A response with an empty queue is discarded and sets err.
- **Simultaneous events:**
  - wr_en and a response to different registers: both commit.
  - A response and ld_issue to the same register in one cycle: the response clears the bit and the issue sets it; the net result is pending = 1.
  - ld_issue and wr_en to the same register in one cycle: the write commits and the register becomes pending.
- **Read:**
  - ra == 0 returns 0.
  - Otherwise the read is bypassed: a value committing this cycle (load response to that register, else the architectural write) is returned; else regs[ra].
- **Busy flags:** busyN = pending[raN] & ~(ld_resp_valid & head == raN & queue non-empty).
- **Queue:** ld_full = (count == LQ_DEPTH). Pointers wrap modulo LQ_DEPTH.
- **err:** cleared only by rst.

## Timing
- Reads, busy flags and bypass are combinational, with zero latency.
- Writes, pending updates, queue push/pop and err take effect at the next rising clk edge.
- A load has a minimum latency of 1 cycle: a response may arrive the cycle after issue, not the same cycle.
- A response in the same cycle as its own issue with an empty queue is treated as an empty-queue response: err is set.
- rst asserted mid-operation discards all in-flight loads at that edge. Responses arriving after reset see an empty queue and set err.

## Test plan
- **Reset, then r0 and source writes:** drive rst for 2 cycles; read r0..r7 → all 0. Then:
  - wr_en to r0 with alu_wd=0xDEADBEEF → r0 still reads 0.
  - Write r3 with src=01, imm=0xA5 → rd1(ra1=3) = 0x000000A5 next cycle.
- **Bypass:** in the same cycle, wr_en r5 = 0x12345678 and ra2=5 → rd2 = 0x12345678 combinationally, while regs[5] updates at the edge.
- **Load-use stall:** issue a load to r2, then idle with ra1=2:
  - busy1 = 1 until the response.
  - In the response cycle (data 0xCAFEF00D), busy1 = 0 and rd1 = 0xCAFEF00D.
  - err stays 0.
- **Queue full and order:** with LQ_DEPTH=2, issue loads r1, r4 → ld_full = 1.
  - A third issue without a response → dropped, err = 1.
  - Responses 0x11, then 0x44 → r1 = 0x11, r4 = 0x44.
  - An issue plus a response in the same cycle while full → accepted, and ld_full stays 1.
- **WAW and empty response:**
  - wr_en to pending r6 → r6 unchanged, err = 1.
  - After rst, ld_resp_valid with an empty queue → err = 1, and no register changes.
- **Reset mid-flight:** issue r7, assert rst for 1 cycle → busy cleared and ld_full = 0. A later response does not write r7 (r7 = 0) and sets err.
